mem_access_unit: RTL and testbench

- Memory-access stage of the multi-cycle CPU. It sits directly downstream of the Controller and consumes its MemRead, MemWrite, IorD and IRWrite outputs.
- Selects the address (PC or ALUOut), runs a req/ready handshake to a variable-latency memory, and holds the Instruction Register (IR) and Memory Data Register (MDR).
- Drives OpCode/Funct back into the Controller.
- Asserts stall so the Controller freezes its state while an access is pending.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/wait_timer.sv | 28 ++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: memory-stage FSM states,
// instruction field positions and the default memory timeout.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    localparam int unsigned OPCODE_MSB      = 31;
    localparam int unsigned OPCODE_LSB      = 26;
    localparam int unsigned FUNCT_MSB       = 5;
    localparam int unsigned FUNCT_LSB       = 0;
    localparam int unsigned TIMER_W         = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wait_timer.sv
// Counts cycles while enabled.
// The expire output flags the last allowed cycle of a wait.
module wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TIMER_W'(1);
        end
    end

    // High during the LIMIT-th enabled cycle since the last clear.
    assign o_expire_c = (r_cnt == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: selects PC/ALUOut, handshakes with a variable-latency
// memory, holds IR/MDR and stalls the Controller while an access is pending.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] instruction,
    output logic [5:0]        OpCode,
    output logic [5:0]        Funct,
    output logic [DATA_W-1:0] mem_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              align_err,
    output logic              timeout_err
);

    mau_state_t        r_state;
    mau_state_t        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic              r_we;
    logic              r_irwrite;
    logic              r_req;
    logic              r_align_err;
    logic              r_timeout_err;

    logic [ADDR_W-1:0] w_addr;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_complete;
    logic              w_abort;
    logic              w_tmr_en;
    logic              w_expire;

    assign w_addr       = IorD ? alu_out : pc;
    assign w_misaligned = (w_addr[1:0] != 2'b00);

    wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (~w_tmr_en),
        .i_en      (w_tmr_en),
        .o_expire_c(w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, stall and datapath strobes.
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_tmr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    w_accept     = 1'b1;
                    stall        = 1'b1;
                    w_next_state = w_misaligned ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall    = 1'b1;
                w_tmr_en = 1'b1;
                if (mem_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            // Controller still drives the served step's signals here.
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_irwrite     <= 1'b0;
            r_req         <= 1'b0;
            r_ir          <= '0;
            r_mdr         <= '0;
            r_align_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= w_addr;
                r_wdata   <= write_data;
                r_we      <= MemWrite;
                r_irwrite <= IRWrite;
                if (w_misaligned) begin
                    r_align_err <= 1'b1;
                end else begin
                    r_req <= 1'b1;
                end
            end
            if (w_complete) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    r_mdr <= mem_rdata;
                    if (r_irwrite) begin
                        r_ir <= mem_rdata;
                    end
                end
            end
            if (w_abort) begin
                r_req         <= 1'b0;
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign instruction = r_ir;
    assign OpCode      = r_ir[OPCODE_MSB:OPCODE_LSB];
    assign Funct       = r_ir[FUNCT_MSB:FUNCT_LSB];
    assign mem_data    = r_mdr;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign align_err   = r_align_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses compared against a transaction-level model of the stage.
module tb_mem_access_unit;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] pc, alu_out, write_data, mem_rdata;
    logic        mem_ready;
    logic [31:0] instruction, mem_data, mem_addr, mem_wdata;
    logic [5:0]  OpCode, Funct;
    logic        stall, mem_req, mem_we, align_err, timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_ir, m_mdr;
    logic        m_align, m_tmo;

    typedef struct {
        int          stall_cnt;
        bit          finished;
        bit          req_seen;
        bit          stable;
        logic        we;
        logic [31:0] addr, wdata, ir, mdr;
        logic [5:0]  opc, fn;
        logic        align, tmo, req_done, post_stall;
    } obs_t;

    typedef struct {
        int          stall_cnt;
        bit          req;
        logic        we;
        logic [31:0] addr, wdata;
    } exp_t;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
        .write_data(write_data), .instruction(instruction), .OpCode(OpCode),
        .Funct(Funct), .mem_data(mem_data), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .align_err(align_err),
        .timeout_err(timeout_err)
    );

    // Transaction model: lat = BUSY cycles until ready (0 = never ready).
    task automatic model_access(input logic rd, wr, iord, irw,
                                input logic [31:0] pcv, aluv, wdv, rdv,
                                input int lat, output exp_t e);
        e.addr  = iord ? aluv : pcv;
        e.we    = wr;
        e.wdata = wdv;
        if (e.addr % 4 != 0) begin
            e.req = 0; e.stall_cnt = 1; m_align = 1'b1;
        end else if (lat >= 1 && lat <= TMO) begin
            e.req = 1; e.stall_cnt = 1 + lat;
            if (!wr) begin
                m_mdr = rdv;
                if (irw) m_ir = rdv;
            end
        end else begin
            e.req = 1; e.stall_cnt = 1 + TMO; m_tmo = 1'b1;
        end
    endtask

    // Controller + memory emulation for one access; returns what was seen.
    task automatic run_access(input logic rd, wr, iord, irw,
                              input logic [31:0] pcv, aluv, wdv, rdv,
                              input int lat, output obs_t o);
        int busy = 0;
        o = '{default: 0};
        o.stable = 1;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        pc = pcv; alu_out = aluv; write_data = wdv; mem_ready = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (mem_req === 1'b1) begin
                busy++;
                if (!o.req_seen) begin
                    o.req_seen = 1; o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
                end else if (mem_addr !== o.addr || mem_wdata !== o.wdata) begin
                    o.stable = 0;
                end
            end
            if (stall === 1'b1) begin
                o.stall_cnt++;
            end else if (cyc > 0) begin
                o.ir = instruction; o.mdr = mem_data; o.opc = OpCode; o.fn = Funct;
                o.align = align_err; o.tmo = timeout_err; o.req_done = mem_req;
                o.finished = 1;
                break;
            end
            mem_ready = (mem_req === 1'b1) && (lat > 0) && (busy == lat);
            mem_rdata = mem_ready ? rdv : $urandom();
            @(negedge clk);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        o.post_stall = stall;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        pc = '0; alu_out = '0; write_data = '0; mem_rdata = '0; mem_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_ir = '0; m_mdr = '0; m_align = 0; m_tmo = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", instruction); end
        checks++; if (mem_data !== 32'h0) begin failures++; $display("FAIL reset_mdr got=%h exp=0", mem_data); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_bus addr=%h wdata=%h we=%b exp all 0", mem_addr, mem_wdata, mem_we); end
        checks++; if (align_err !== 1'b0 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL reset_flags align=%b tmo=%b exp 0/0", align_err, timeout_err); end
    endtask

    task automatic test_fetch();
        obs_t o; exp_t e;
        model_access(1, 0, 0, 1, 32'h4, 32'h100, 32'h0, 32'h2009_0005, 1, e);
        run_access(1, 0, 0, 1, 32'h4, 32'h100, 32'h0, 32'h2009_0005, 1, o);
        checks++; if (o.addr !== 32'h4 || o.we !== 1'b0) begin failures++; $display("FAIL fetch_bus addr=%h we=%b exp 4/0", o.addr, o.we); end
        checks++; if (o.stall_cnt != 2) begin failures++; $display("FAIL fetch_stall got=%0d exp=2", o.stall_cnt); end
        checks++; if (o.ir !== m_ir) begin failures++; $display("FAIL fetch_ir got=%h exp=%h", o.ir, m_ir); end
        checks++; if (o.opc !== 6'h08 || o.fn !== 6'h05) begin failures++; $display("FAIL fetch_fields op=%h fn=%h exp 08/05", o.opc, o.fn); end
        checks++; if (o.mdr !== m_mdr) begin failures++; $display("FAIL fetch_mdr got=%h exp=%h", o.mdr, m_mdr); end
        checks++; if (o.post_stall !== 1'b0) begin failures++; $display("FAIL fetch_done_ignores got=%b exp=0", o.post_stall); end
    endtask

    task automatic test_lw();
        obs_t o; exp_t e;
        model_access(1, 0, 1, 0, 32'h8, 32'h10, 32'h0, 32'hDEAD_BEEF, 3, e);
        run_access(1, 0, 1, 0, 32'h8, 32'h10, 32'h0, 32'hDEAD_BEEF, 3, o);
        checks++; if (o.addr !== 32'h10) begin failures++; $display("FAIL lw_addr got=%h exp=10", o.addr); end
        checks++; if (o.stall_cnt != 4) begin failures++; $display("FAIL lw_stall got=%0d exp=4", o.stall_cnt); end
        checks++; if (o.mdr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_mdr got=%h exp=deadbeef", o.mdr); end
        checks++; if (o.ir !== m_ir) begin failures++; $display("FAIL lw_ir_kept got=%h exp=%h", o.ir, m_ir); end
    endtask

    task automatic test_sw();
        obs_t o; exp_t e;
        model_access(0, 1, 1, 0, 32'h8, 32'h20, 32'h1234_5678, 32'hAAAA_5555, 2, e);
        run_access(0, 1, 1, 0, 32'h8, 32'h20, 32'h1234_5678, 32'hAAAA_5555, 2, o);
        checks++; if (!o.req_seen || o.we !== 1'b1) begin failures++; $display("FAIL sw_req seen=%0d we=%b exp 1/1", o.req_seen, o.we); end
        checks++; if (o.addr !== 32'h20 || o.wdata !== 32'h1234_5678) begin
            failures++; $display("FAIL sw_bus addr=%h wdata=%h exp 20/12345678", o.addr, o.wdata); end
        checks++; if (!o.stable) begin failures++; $display("FAIL sw_stable got=0 exp=1"); end
        checks++; if (o.mdr !== m_mdr || o.stall_cnt != 3) begin
            failures++; $display("FAIL sw_mdr mdr=%h stall=%0d exp %h/3", o.mdr, o.stall_cnt, m_mdr); end
    endtask

    task automatic test_misaligned_and_both();
        obs_t o; exp_t e;
        model_access(1, 0, 1, 0, 32'h0, 32'h22, 32'h0, 32'h1111_2222, 1, e);
        run_access(1, 0, 1, 0, 32'h0, 32'h22, 32'h0, 32'h1111_2222, 1, o);
        checks++; if (o.req_seen) begin failures++; $display("FAIL mis_req got=1 exp=0"); end
        checks++; if (o.stall_cnt != 1) begin failures++; $display("FAIL mis_stall got=%0d exp=1", o.stall_cnt); end
        checks++; if (o.align !== 1'b1 || o.mdr !== m_mdr) begin
            failures++; $display("FAIL mis_flag align=%b mdr=%h exp 1/%h", o.align, o.mdr, m_mdr); end
        model_access(1, 1, 1, 1, 32'h0, 32'h30, 32'hCAFE_F00D, 32'h7777_8888, 2, e);
        run_access(1, 1, 1, 1, 32'h0, 32'h30, 32'hCAFE_F00D, 32'h7777_8888, 2, o);
        checks++; if (o.we !== 1'b1 || o.wdata !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL both_write we=%b wdata=%h exp 1/cafef00d", o.we, o.wdata); end
        checks++; if (o.mdr !== m_mdr || o.ir !== m_ir) begin
            failures++; $display("FAIL both_regs mdr=%h ir=%h exp %h/%h", o.mdr, o.ir, m_mdr, m_ir); end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        model_access(1, 0, 1, 1, 32'h0, 32'h40, 32'h0, 32'h9999_9999, 0, e);
        run_access(1, 0, 1, 1, 32'h0, 32'h40, 32'h0, 32'h9999_9999, 0, o);
        checks++; if (!o.finished) begin failures++; $display("FAIL tmo_done got=unfinished exp=finished"); end
        checks++; if (o.stall_cnt != 1 + TMO) begin failures++; $display("FAIL tmo_stall got=%0d exp=%0d", o.stall_cnt, 1 + TMO); end
        checks++; if (o.tmo !== 1'b1 || o.req_done !== 1'b0) begin
            failures++; $display("FAIL tmo_flag tmo=%b req=%b exp 1/0", o.tmo, o.req_done); end
        checks++; if (o.ir !== m_ir || o.mdr !== m_mdr) begin
            failures++; $display("FAIL tmo_regs ir=%h mdr=%h exp %h/%h", o.ir, o.mdr, m_ir, m_mdr); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        MemRead = 1; MemWrite = 0; IorD = 1; IRWrite = 1; alu_out = 32'h80; mem_ready = 0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
        @(negedge clk);
        reset = 1'b1; MemRead = 0;
        @(negedge clk);
        reset = 1'b0;
        m_ir = '0; m_mdr = '0; m_align = 0; m_tmo = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL rst_mid req=%b stall=%b exp 0/0", mem_req, stall); end
        checks++; if (instruction !== 32'h0 || mem_data !== 32'h0) begin
            failures++; $display("FAIL rst_mid_regs ir=%h mdr=%h exp 0/0", instruction, mem_data); end
        checks++; if (align_err !== 1'b0 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL rst_mid_flags align=%b tmo=%b exp 0/0", align_err, timeout_err); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic rd, wr, iord, irw;
        logic [31:0] pcv, aluv, wdv, rdv;
        int sel, lat;
        for (int n = 0; n < 40; n++) begin
            sel  = $urandom_range(0, 2);
            rd   = (sel != 1); wr = (sel != 0);
            iord = 1'($urandom_range(0, 1)); irw = 1'($urandom_range(0, 1));
            pcv  = $urandom() & 32'hFFFF_FFFC; aluv = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) begin
                if (iord) aluv = aluv | 32'($urandom_range(1, 3));
                else      pcv  = pcv  | 32'($urandom_range(1, 3));
            end
            wdv = $urandom(); rdv = $urandom(); lat = $urandom_range(1, 5);
            model_access(rd, wr, iord, irw, pcv, aluv, wdv, rdv, lat, e);
            run_access(rd, wr, iord, irw, pcv, aluv, wdv, rdv, lat, o);
            checks++; if (o.stall_cnt != e.stall_cnt || o.req_seen != e.req) begin
                failures++; $display("FAIL rnd%0d_flow stall=%0d req=%0d exp %0d/%0d", n, o.stall_cnt, o.req_seen, e.stall_cnt, e.req); end
            if (e.req) begin
                checks++; if (o.addr !== e.addr || o.we !== e.we || (e.we && o.wdata !== e.wdata) || !o.stable) begin
                    failures++; $display("FAIL rnd%0d_bus addr=%h we=%b wdata=%h stable=%0d exp %h/%b/%h/1",
                                         n, o.addr, o.we, o.wdata, o.stable, e.addr, e.we, e.wdata); end
            end
            checks++; if (o.ir !== m_ir || o.mdr !== m_mdr) begin
                failures++; $display("FAIL rnd%0d_regs ir=%h mdr=%h exp %h/%h", n, o.ir, o.mdr, m_ir, m_mdr); end
            checks++; if (o.align !== m_align || o.tmo !== m_tmo || o.post_stall !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_flags align=%b tmo=%b post=%b exp %b/%b/0",
                                     n, o.align, o.tmo, o.post_stall, m_align, m_tmo); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_lw();
        test_sw();
        test_misaligned_and_both();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
